// File: rtl/set_assoc_bpu.sv
// Set-associative branch prediction unit.
// Each set holds WAYS entries of {valid, tag, target, saturating counter, age}.
// Lookup is purely combinational; updates, allocation and flush happen on the
// rising clock edge. Replacement is true LRU: age 0 is most recently used and
// the way with age WAYS-1 is the victim once every way of the set is valid.
module set_assoc_bpu #(
  parameter int IDX_SIZE  = 4,
  parameter int WAYS      = 2,
  parameter int CNT_WIDTH = 2,
  parameter int TAG_SIZE  = 30 - IDX_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pc_predict
);

  localparam int SETS  = 1 << IDX_SIZE;
  // With a single way there is no age information; a 1-bit field pinned to 0 stands in.
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_INIT   = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic [AGE_W-1:0]     AGE_OLDEST = AGE_W'(WAYS - 1);

  logic                 valid_r  [SETS][WAYS];
  logic [TAG_SIZE-1:0]  tag_r    [SETS][WAYS];
  logic [31:0]          target_r [SETS][WAYS];
  logic [CNT_WIDTH-1:0] cnt_r    [SETS][WAYS];
  logic [AGE_W-1:0]     age_r    [SETS][WAYS];

  logic [IDX_SIZE-1:0]  rd_set_s;
  logic [TAG_SIZE-1:0]  rd_tag_s;
  logic                 rd_hit_s;
  logic [AGE_W-1:0]     rd_way_s;
  logic [IDX_SIZE-1:0]  up_set_s;
  logic [TAG_SIZE-1:0]  up_tag_s;
  logic                 up_hit_s;
  logic [AGE_W-1:0]     up_way_s;
  logic                 inv_found_s;
  logic [AGE_W-1:0]     inv_way_s;
  logic [AGE_W-1:0]     old_way_s;
  logic [AGE_W-1:0]     wr_way_s;
  logic                 wr_en_s;
  logic [CNT_WIDTH-1:0] new_cnt_s;
  logic                 unused_s;

  // Saturating up/down step of a prediction counter.
  function automatic logic [CNT_WIDTH-1:0] sat_next(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic up);
    logic [CNT_WIDTH-1:0] res;
    if (up) begin
      if (cnt == CNT_MAX) res = cnt;
      else                res = cnt + CNT_WIDTH'(1);
    end else begin
      if (cnt == CNT_ZERO) res = cnt;
      else                 res = cnt - CNT_WIDTH'(1);
    end
    return res;
  endfunction

  // Byte-offset bits of the update PC carry no information.
  assign unused_s = ^upd_pc[1:0];

  assign rd_set_s = pc[IDX_SIZE+1:2];
  assign rd_tag_s = pc[31:IDX_SIZE+2];
  assign up_set_s = upd_pc[IDX_SIZE+1:2];
  assign up_tag_s = upd_pc[31:IDX_SIZE+2];

  // Fetch-side lookup: find the (unique) valid way whose tag matches pc.
  always_comb begin
    rd_hit_s = 1'b0;
    rd_way_s = {AGE_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (valid_r[rd_set_s][w] && (tag_r[rd_set_s][w] == rd_tag_s)) begin
        rd_hit_s = 1'b1;
        rd_way_s = AGE_W'(w);
      end else begin
        rd_hit_s = rd_hit_s;
      end
    end
  end

  assign pred_hit   = rd_hit_s;
  assign pred_taken = rd_hit_s & cnt_r[rd_set_s][rd_way_s][CNT_WIDTH-1];
  assign pc_predict = pred_taken ? target_r[rd_set_s][rd_way_s] : (pc + 32'd4);

  // Update-side lookup plus victim choice (lowest invalid way, else the oldest way).
  always_comb begin
    up_hit_s    = 1'b0;
    up_way_s    = {AGE_W{1'b0}};
    inv_found_s = 1'b0;
    inv_way_s   = {AGE_W{1'b0}};
    old_way_s   = {AGE_W{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      if (valid_r[up_set_s][w] && (tag_r[up_set_s][w] == up_tag_s)) begin
        up_hit_s = 1'b1;
        up_way_s = AGE_W'(w);
      end else begin
        up_hit_s = up_hit_s;
      end
      if (!inv_found_s && !valid_r[up_set_s][w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = AGE_W'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
      if (age_r[up_set_s][w] == AGE_OLDEST) begin
        old_way_s = AGE_W'(w);
      end else begin
        old_way_s = old_way_s;
      end
    end
  end

  // A not-taken miss leaves everything alone; flush and reset swallow the update.
  assign wr_en_s   = rst & upd_valid & ~flush & (up_hit_s | upd_taken);
  assign wr_way_s  = up_hit_s ? up_way_s : (inv_found_s ? inv_way_s : old_way_s);
  assign new_cnt_s = up_hit_s ? sat_next(cnt_r[up_set_s][up_way_s], upd_taken) : CNT_INIT;

  // Valid bits and LRU ages: async reset / flush restore age(way i)=i, writes make the way MRU.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          age_r[s][w]   <= AGE_W'(w);
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_r[s][w] <= 1'b0;
          age_r[s][w]   <= AGE_W'(w);
        end
      end
    end else if (wr_en_s) begin
      valid_r[up_set_s][wr_way_s] <= 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == wr_way_s) begin
          age_r[up_set_s][w] <= {AGE_W{1'b0}};
        end else if (age_r[up_set_s][w] < age_r[up_set_s][wr_way_s]) begin
          age_r[up_set_s][w] <= age_r[up_set_s][w] + AGE_W'(1);
        end else begin
          age_r[up_set_s][w] <= age_r[up_set_s][w];
        end
      end
    end else begin
      valid_r <= valid_r;
    end
  end

  // Entry payload: needs no reset since it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tag_r[up_set_s][wr_way_s] <= up_tag_s;
      cnt_r[up_set_s][wr_way_s] <= new_cnt_s;
      if (upd_taken) begin
        target_r[up_set_s][wr_way_s] <= upd_target;
      end else begin
        target_r[up_set_s][wr_way_s] <= target_r[up_set_s][wr_way_s];
      end
    end else begin
      tag_r <= tag_r;
    end
  end

endmodule
